// File: rtl/timebase_gen_if.sv
// Control and status bundle for timebase_gen: run/clear in, square wave, tick and elapsed count out.
interface timebase_gen_if #(
   parameter int ELAPSED_W = 16
);
   logic                 start;
   logic                 clear;
   logic                 sq;
   logic                 tick;
   logic [ELAPSED_W-1:0] elapsed;
   logic                 sat;

   modport master (output start, clear, input sq, tick, elapsed, sat);
   modport slave  (input start, clear, output sq, tick, elapsed, sat);
endinterface

// File: rtl/timebase_gen.sv
// Timebase: sq/tick at TICK_HZ from clk, saturating elapsed count; all outputs registered, first tick HALF edges after reset.
// No backpressure; start=0 freezes state. TIMEBASE_BCD_EN selects packed-BCD elapsed instead of binary.
module timebase_gen #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int TICK_HZ   = 10,
   parameter int CNT_W     = 32,
   parameter int ELAPSED_W = 16
) (
   input logic           clk,
   input logic           rst,
   timebase_gen_if.slave bus
);
   localparam int HALF = CLK_HZ / (2 * TICK_HZ);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

   logic [CNT_W-1:0]     cnt;
   logic                 sq_q;
   logic                 tick_q;
   logic                 sat_q;
   logic [ELAPSED_W-1:0] elapsed_q;
   logic [ELAPSED_W-1:0] elapsed_inc;
   logic                 wrap;

   assign wrap = (cnt == LAST);

`ifdef TIMEBASE_BCD_EN
   localparam int DIGITS = ELAPSED_W / 4;
   localparam logic [ELAPSED_W-1:0] MAX = {DIGITS{4'h9}};

   // Decimal increment: each digit wraps 9->0 and passes the carry up within the cycle.
   always_comb begin
      logic carry;
      elapsed_inc = elapsed_q;
      carry       = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (elapsed_q[4*i +: 4] == 4'd9) begin
               elapsed_inc[4*i +: 4] = 4'd0;
            end else begin
               elapsed_inc[4*i +: 4] = elapsed_q[4*i +: 4] + 4'd1;
               carry                 = 1'b0;
            end
         end
      end
   end
`else
   localparam logic [ELAPSED_W-1:0] MAX = '1;

   assign elapsed_inc = elapsed_q + ELAPSED_W'(1);
`endif

   always_ff @(posedge clk) begin
      if (rst || bus.clear) begin
         cnt       <= '0;
         sq_q      <= 1'b0;
         tick_q    <= 1'b0;
         elapsed_q <= '0;
         sat_q     <= 1'b0;
      end else if (bus.start) begin
         if (wrap) begin
            cnt    <= '0;
            sq_q   <= ~sq_q;
            tick_q <= ~sq_q;
            // Only the rising half advances the count; at MAX the count holds but sq/tick keep going.
            if (!sq_q && (elapsed_q != MAX)) begin
               elapsed_q <= elapsed_inc;
               sat_q     <= (elapsed_inc == MAX);
            end
         end else begin
            cnt    <= cnt + CNT_W'(1);
            tick_q <= 1'b0;
         end
      end else begin
         tick_q <= 1'b0;
      end
   end

   assign bus.sq      = sq_q;
   assign bus.tick    = tick_q;
   assign bus.elapsed = elapsed_q;
   assign bus.sat     = sat_q;
endmodule

// File: tb/tb_timebase_gen.sv
// Bench for timebase_gen at HALF=5: expected outputs derived from running-edge count, queued per edge.
module tb_timebase_gen;
   localparam int H = 5;
`ifdef TIMEBASE_BCD_EN
   localparam int EW   = 8;
   localparam int MAXN = 99;
`else
   localparam int EW   = 4;
   localparam int MAXN = 15;
`endif

   typedef struct {
      logic          sq;
      logic          tick;
      logic [EW-1:0] el;
      logic          sat;
   } exp_t;

   logic clk;
   logic rst;
   exp_t sb[$];
   int   run_n;
   logic tick_exp;
   int   n_checks;
   int   n_pass;

   timebase_gen_if #(.ELAPSED_W(EW)) bus ();

   timebase_gen #(
      .CLK_HZ   (100),
      .TICK_HZ  (10),
      .CNT_W    (8),
      .ELAPSED_W(EW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [EW-1:0] enc(input int n);
      logic [EW-1:0] r;
`ifdef TIMEBASE_BCD_EN
      int v = n;
      r = '0;
      for (int i = 0; i < EW / 4; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
`else
      r = EW'(n);
`endif
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One clock edge: drive inputs, queue what the outputs must be after it, then compare.
   task automatic step(input logic r, input logic s, input logic c);
      exp_t e;
      exp_t o;
      int   n;
      @(negedge clk);
      rst       = r;
      bus.start = s;
      bus.clear = c;
      if (r || c) begin
         run_n    = 0;
         tick_exp = 1'b0;
      end else if (s) begin
         run_n++;
         tick_exp = ((run_n % (2 * H)) == H);
      end else begin
         tick_exp = 1'b0;
      end
      n      = (run_n + H) / (2 * H);
      e.sq   = ((run_n / H) % 2) == 1;
      e.tick = tick_exp;
      e.el   = enc((n < MAXN) ? n : MAXN);
      e.sat  = (n >= MAXN);
      sb.push_back(e);
      @(posedge clk);
      #1;
      o = sb.pop_front();
      check("sq", 32'(bus.sq), 32'(o.sq));
      check("tick", 32'(bus.tick), 32'(o.tick));
      check("elapsed", 32'(bus.elapsed), 32'(o.el));
      check("sat", 32'(bus.sat), 32'(o.sat));
   endtask

   task automatic run(input int n, input logic s);
      repeat (n) step(1'b0, s, 1'b0);
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.clear = 1'b0;
      run_n     = 0;
      tick_exp  = 1'b0;
      n_checks  = 0;
      n_pass    = 0;

      // Reset with start held high
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check("rst_elapsed", 32'(bus.elapsed), 32'(0));
      check("rst_sq", 32'(bus.sq), 32'(0));

      // First period latency
      run(5, 1'b1);
      check("t1_e5_sq", 32'(bus.sq), 32'(1));
      check("t1_e5_tick", 32'(bus.tick), 32'(1));
      check("t1_e5_el", 32'(bus.elapsed), 32'(enc(1)));
      run(1, 1'b1);
      check("t1_e6_tick", 32'(bus.tick), 32'(0));
      run(4, 1'b1);
      check("t1_e10_sq", 32'(bus.sq), 32'(0));
      run(5, 1'b1);
      check("t1_e15_tick", 32'(bus.tick), 32'(1));
      check("t1_e15_el", 32'(bus.elapsed), 32'(enc(2)));

      // Pause preserves partial period
      step(1'b0, 1'b1, 1'b1);
      run(3, 1'b1);
      run(20, 1'b0);
      check("t2_pause_sq", 32'(bus.sq), 32'(0));
      check("t2_pause_el", 32'(bus.elapsed), 32'(0));
      run(1, 1'b1);
      check("t2_resume1_sq", 32'(bus.sq), 32'(0));
      run(1, 1'b1);
      check("t2_resume2_sq", 32'(bus.sq), 32'(1));
      check("t2_resume2_tick", 32'(bus.tick), 32'(1));

      // Clear mid-period with start high
      step(1'b0, 1'b1, 1'b1);
      run(3, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      check("t3_clr_sq", 32'(bus.sq), 32'(0));
      check("t3_clr_el", 32'(bus.elapsed), 32'(0));
      run(4, 1'b1);
      check("t3_e4_tick", 32'(bus.tick), 32'(0));
      run(1, 1'b1);
      check("t3_e5_tick", 32'(bus.tick), 32'(1));

      // Reset mid-period
      run(7, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      check("t6_rst_sq", 32'(bus.sq), 32'(0));
      check("t6_rst_el", 32'(bus.elapsed), 32'(0));
      run(4, 1'b1);
      check("t6_e4_tick", 32'(bus.tick), 32'(0));
      run(1, 1'b1);
      check("t6_e5_tick", 32'(bus.tick), 32'(1));
      check("t6_e5_el", 32'(bus.elapsed), 32'(enc(1)));

      // Saturation
      step(1'b0, 1'b1, 1'b1);
      run(H + (MAXN - 2) * 2 * H, 1'b1);
      check("t4_premax_sat", 32'(bus.sat), 32'(0));
      run(2 * H, 1'b1);
      check("t4_max_el", 32'(bus.elapsed), 32'(enc(MAXN)));
      check("t4_max_sat", 32'(bus.sat), 32'(1));
      run(2 * H, 1'b1);
      check("t4_over_tick", 32'(bus.tick), 32'(1));
      check("t4_over_el", 32'(bus.elapsed), 32'(enc(MAXN)));
      check("t4_over_sat", 32'(bus.sat), 32'(1));

      // Random start/clear mix
      step(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 300; i++) begin
         step(1'b0, ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
